// File: rtl/bin_to_rns_serial.sv
// -----------------------------------------------------------------------------
// bin_to_rns_serial
//   Bit-serial forward converter from DATA_W-bit binary to the residue number
//   system with moduli {M1, M2, M3}. The operand is consumed MSB-first, one bit
//   per clock, so a conversion occupies DATA_W BUSY cycles. Each channel keeps
//   a running residue r and folds in the next bit with r <= (2r+b) mod Mi using
//   a single conditional subtract. Inputs at or above M1*M2*M3 are still
//   converted but flagged on range_err_out.
//
// Ports
//   clk_in        in   clock, rising edge
//   rst_in        in   asynchronous reset, active-high
//   x_in          in   binary operand, sampled only when accepted
//   in_valid_in   in   x_in is valid
//   in_ready_out  out  converter is idle and will accept x_in this cycle
//   r1_out        out  x mod M1 (zero-extended to R1_W)
//   r2_out        out  x mod M2 (zero-extended to R2_W)
//   r3_out        out  x mod M3 (zero-extended to R3_W)
//   range_err_out out  x >= M1*M2*M3, qualified by out_valid_out
//   out_valid_out out  residues valid
//   out_ready_in  in   consumer takes the residues this cycle
//
// All outputs are registers; there is no combinational input-to-output path.
// Output values persist after out_valid_out drops until the next result.
// -----------------------------------------------------------------------------
module bin_to_rns_serial #(
    parameter int DATA_W = 9,
    parameter int M1     = 7,
    parameter int M2     = 8,
    parameter int M3     = 9,
    parameter int R1_W   = 4,
    parameter int R2_W   = 4,
    parameter int R3_W   = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [DATA_W-1:0] x_in,
    input  logic              in_valid_in,
    output logic              in_ready_out,
    output logic [R1_W-1:0]   r1_out,
    output logic [R2_W-1:0]   r2_out,
    output logic [R3_W-1:0]   r3_out,
    output logic              range_err_out,
    output logic              out_valid_out,
    input  logic              out_ready_in
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int NCH   = 3;
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int RANGE = M1 * M2 * M3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int mod_of(input int idx);
        case (idx)
            0:       return M1;
            1:       return M2;
            default: return M3;
        endcase
    endfunction

    // Common accumulator width wide enough for every channel's residue.
    localparam int ACC_W = max3(R1_W, R2_W, R3_W);

    // If the dynamic range does not fit in DATA_W bits, no input can exceed it.
    localparam bit                RANGE_FITS = (RANGE < (1 << DATA_W));
    localparam logic [DATA_W-1:0] RANGE_V    = DATA_W'(RANGE);

    logic [1:0]                  state_reg;
    logic [DATA_W-1:0]           shift_reg;
    logic [CNT_W-1:0]            cnt_reg;
    logic                        err_reg;
    logic [NCH-1:0][ACC_W-1:0]   acc_reg;
    logic [NCH-1:0][ACC_W-1:0]   acc_next;
    logic                        serial_bit;

    assign serial_bit = shift_reg[DATA_W-1];

    // One residue update per channel: t = 2*r + b is just r shifted left with
    // b appended. Since r < Mi, t < 2*Mi, so one conditional subtract suffices.
    // A power-of-two modulus goes through the same logic unchanged.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            localparam int              MOD   = mod_of(gi);
            localparam logic [ACC_W:0]  MOD_V = (ACC_W + 1)'(MOD);
            logic [ACC_W:0] t_next;
            logic [ACC_W:0] t_sub;

            assign t_next       = {acc_reg[gi], serial_bit};
            assign t_sub        = t_next - MOD_V;
            assign acc_next[gi] = (t_next >= MOD_V) ? t_sub[ACC_W-1:0]
                                                    : t_next[ACC_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
            acc_reg       <= '0;
            in_ready_out  <= 1'b1;
            out_valid_out <= 1'b0;
            r1_out        <= '0;
            r2_out        <= '0;
            r3_out        <= '0;
            range_err_out <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid_in) begin
                        shift_reg    <= x_in;
                        acc_reg      <= '0;
                        cnt_reg      <= CNT_W'(DATA_W);
                        err_reg      <= RANGE_FITS && (x_in >= RANGE_V);
                        in_ready_out <= 1'b0;
                        state_reg    <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    shift_reg <= shift_reg << 1;
                    acc_reg   <= acc_next;
                    cnt_reg   <= cnt_reg - 1'b1;
                    // Last bit: publish the freshly folded residues directly.
                    if (cnt_reg == CNT_W'(1)) begin
                        r1_out        <= R1_W'(acc_next[0]);
                        r2_out        <= R2_W'(acc_next[1]);
                        r3_out        <= R3_W'(acc_next[2]);
                        range_err_out <= err_reg;
                        out_valid_out <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready_in) begin
                        out_valid_out <= 1'b0;
                        in_ready_out  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid_out <= 1'b0;
                    in_ready_out  <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_rns_serial.sv
// -----------------------------------------------------------------------------
// tb_bin_to_rns_serial
//   Directed and randomized checks of bin_to_rns_serial. Expected residues come
//   from plain arithmetic (x % Mi) and the range rule x >= 504.
// -----------------------------------------------------------------------------
module tb_bin_to_rns_serial;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [8:0] x_in;
    logic       in_valid_in;
    logic       in_ready_out;
    logic [3:0] r1_out;
    logic [3:0] r2_out;
    logic [4:0] r3_out;
    logic       range_err_out;
    logic       out_valid_out;
    logic       out_ready_in;

    int checks = 0;
    int errors = 0;

    bin_to_rns_serial dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .x_in          (x_in),
        .in_valid_in   (in_valid_in),
        .in_ready_out  (in_ready_out),
        .r1_out        (r1_out),
        .r2_out        (r2_out),
        .r3_out        (r3_out),
        .range_err_out (range_err_out),
        .out_valid_out (out_valid_out),
        .out_ready_in  (out_ready_in)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check_result(input string tag, input int x);
        check({tag, "_r1"}, 32'(r1_out), x % 7);
        check({tag, "_r2"}, 32'(r2_out), x % 8);
        check({tag, "_r3"}, 32'(r3_out), x % 9);
        check({tag, "_err"}, 32'(range_err_out), (x >= 504) ? 1 : 0);
    endtask

    // Accept one operand, measure latency, optionally stall in DONE, then take it.
    task automatic convert(input int x, input int hold);
        int lat;
        for (int i = 0; i < 30 && !in_ready_out; i++) step();
        check("ready_idle", 32'(in_ready_out), 1);
        x_in        = 9'(x);
        in_valid_in = 1'b1;
        step();
        in_valid_in = 1'b0;
        x_in        = 9'($urandom);
        check("ready_busy", 32'(in_ready_out), 0);
        lat = 0;
        while (!out_valid_out && lat < 30) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 9);
        check_result("conv", x);
        for (int i = 0; i < hold; i++) begin
            out_ready_in = 1'b0;
            step();
            check("hold_valid", 32'(out_valid_out), 1);
            check("hold_ready", 32'(in_ready_out), 0);
            check_result("hold", x);
        end
        out_ready_in = 1'b1;
        step();
        out_ready_in = 1'b0;
        check("taken_valid", 32'(out_valid_out), 0);
        check("taken_ready", 32'(in_ready_out), 1);
        $display("conv x=%0d res=(%0d,%0d,%0d) err=%0d lat=%0d", x, r1_out, r2_out, r3_out, range_err_out, lat);
    endtask

    initial begin
        int sent;
        int recv;
        int cycles;
        int spurious;
        int e;
        bit fire_in;
        bit fire_out;
        int q[$];

        rst_in       = 1'b0;
        x_in         = '0;
        in_valid_in  = 1'b0;
        out_ready_in = 1'b0;
        #2 rst_in = 1'b1;
        #1;
        check("rst_ready", 32'(in_ready_out), 1);
        check("rst_valid", 32'(out_valid_out), 0);
        check("rst_r1", 32'(r1_out), 0);
        check("rst_r2", 32'(r2_out), 0);
        check("rst_r3", 32'(r3_out), 0);
        check("rst_err", 32'(range_err_out), 0);
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b0;
        step();

        // Directed values including both sides of the range boundary.
        convert(0, 0);
        convert(100, 0);
        convert(503, 0);
        convert(504, 0);
        convert(511, 5);

        // Asynchronous reset in the middle of a conversion.
        x_in        = 9'd200;
        in_valid_in = 1'b1;
        step();
        in_valid_in = 1'b0;
        repeat (4) step();
        rst_in = 1'b1;
        #1;
        check("arst_ready", 32'(in_ready_out), 1);
        check("arst_valid", 32'(out_valid_out), 0);
        check("arst_r1", 32'(r1_out), 0);
        check("arst_r2", 32'(r2_out), 0);
        check("arst_r3", 32'(r3_out), 0);
        check("arst_err", 32'(range_err_out), 0);
        $display("async reset during busy: ready=%0d valid=%0d", in_ready_out, out_valid_out);
        #2 rst_in = 1'b0;
        step();
        convert(37, 0);

        // Full sweep with random valid/ready gaps; one in flight at most.
        sent   = 0;
        recv   = 0;
        cycles = 0;
        while (recv < 512 && cycles < 30000) begin
            in_valid_in  = (sent < 512) && ($urandom_range(0, 2) != 0);
            x_in         = in_valid_in ? 9'(sent) : 9'($urandom);
            out_ready_in = ($urandom_range(0, 2) != 0);
            fire_in  = in_valid_in && in_ready_out;
            fire_out = out_valid_out && out_ready_in;
            if (fire_out) begin
                if (q.size() == 0) begin
                    check("sweep_extra", 1, 0);
                end else begin
                    e = q.pop_front();
                    check_result("sweep", e);
                    $display("sweep x=%0d res=(%0d,%0d,%0d) err=%0d", e, r1_out, r2_out, r3_out, range_err_out);
                end
                recv++;
            end
            if (fire_in) begin
                q.push_back(sent);
                sent++;
            end
            step();
            cycles++;
        end
        in_valid_in  = 1'b0;
        out_ready_in = 1'b1;
        check("sweep_recv", 32'(recv), 512);
        check("sweep_sent", 32'(sent), 512);
        check("sweep_queue", 32'(q.size()), 0);
        spurious = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid_out) spurious++;
        end
        check("sweep_spurious", 32'(spurious), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
